// File: rtl/debug_controller_if.sv
// Bundles the UART byte stream, datapath debug ports and memory debug ports of debug_controller.
// The controller uses modport master; the UART/datapath side uses modport slave.
interface debug_controller_if #(
  parameter int UART_BITS        = 8,
  parameter int PC_BITS          = 32,
  parameter int INSTRUCTION_BITS = 32,
  parameter int PROC_BITS        = 32,
  parameter int DATA_ADDRS_BITS  = 5,
  parameter int SNAP_BITS        = 1024
);
  logic                        i_rx_done;
  logic [UART_BITS-1:0]        i_rx_data;
  logic                        i_tx_done;
  logic                        o_tx_start;
  logic [UART_BITS-1:0]        o_tx_data;
  logic                        i_halt;
  logic [SNAP_BITS-1:0]        i_snapshot;
  logic [PROC_BITS-1:0]        i_mem_data;
  logic                        o_enable;
  logic                        o_write_inst_mem;
  logic [PC_BITS-1:0]          o_inst_mem_addr;
  logic [INSTRUCTION_BITS-1:0] o_inst_mem_data;
  logic                        o_debug_read_data;
  logic [DATA_ADDRS_BITS-1:0]  o_debug_read_address;
  logic                        o_busy;

  modport master (
    input  i_rx_done, i_rx_data, i_tx_done, i_halt, i_snapshot, i_mem_data,
    output o_tx_start, o_tx_data, o_enable, o_write_inst_mem, o_inst_mem_addr,
           o_inst_mem_data, o_debug_read_data, o_debug_read_address, o_busy
  );

  modport slave (
    output i_rx_done, i_rx_data, i_tx_done, i_halt, i_snapshot, i_mem_data,
    input  o_tx_start, o_tx_data, o_enable, o_write_inst_mem, o_inst_mem_addr,
           o_inst_mem_data, o_debug_read_data, o_debug_read_address, o_busy
  );
endinterface

// File: rtl/debug_controller.sv
// UART-driven debug controller: instruction load, run/step control, cycle counter + snapshot dump.
// Define DBG_MEM_DUMP_EN to append a full data memory dump after the snapshot bytes.
module debug_controller #(
  parameter int UART_BITS        = 8,
  parameter int PC_BITS          = 32,
  parameter int INSTRUCTION_BITS = 32,
  parameter int PROC_BITS        = 32,
  parameter int DATA_ADDRS_BITS  = 5,
  parameter int SNAP_BITS        = 1024,
  parameter int CYCLE_BITS       = 32
) (
  input logic clk,
  input logic rst,
  debug_controller_if.master bus
);
  localparam int IB        = INSTRUCTION_BITS / 8;
  localparam int BI_W      = $clog2(IB + 1);
  localparam int DUMP_W    = CYCLE_BITS + SNAP_BITS;
  localparam int HDR_BYTES = DUMP_W / 8;
  localparam int DL_W      = 16;

  typedef enum logic [3:0] {
    IDLE, LOAD_CNT, LOAD_DATA, SEND_ACK, RUN, STEP, DUMP_LATCH, DUMP_TX,
    MEM_REQ, MEM_WAIT, MEM_SAMPLE, MEM_TX
  } state_t;

  state_t                      state;
  logic                        enable_q;
  logic                        en;
  logic [CYCLE_BITS-1:0]       cycle_cnt;
  logic                        tx_busy;
  logic                        tx_start_q;
  logic [UART_BITS-1:0]        tx_data_q;
  logic                        write_q;
  logic [PC_BITS-1:0]          inst_addr_q;
  logic [INSTRUCTION_BITS-1:0] word_q;
  logic [BI_W-1:0]             byte_idx;
  logic [7:0]                  inst_idx;
  logic [7:0]                  inst_total;
  logic [7:0]                  ack_q;
  logic [DUMP_W-1:0]           dump_q;
  logic [DL_W-1:0]             dump_left;
`ifdef DBG_MEM_DUMP_EN
  localparam int WB = PROC_BITS / 8;
  logic                       read_q;
  logic [DATA_ADDRS_BITS-1:0] read_addr_q;
`endif

  // Halt gates the enable in the same cycle; STEP deliberately ignores halt.
  assign en = rst & enable_q & ~(bus.i_halt & (state == RUN));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      enable_q    <= 1'b0;
      cycle_cnt   <= '0;
      tx_busy     <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      write_q     <= 1'b0;
      inst_addr_q <= '0;
      word_q      <= '0;
      byte_idx    <= '0;
      inst_idx    <= '0;
      inst_total  <= '0;
      ack_q       <= '0;
      dump_q      <= '0;
      dump_left   <= '0;
`ifdef DBG_MEM_DUMP_EN
      read_q      <= 1'b0;
      read_addr_q <= '0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      write_q    <= 1'b0;
`ifdef DBG_MEM_DUMP_EN
      read_q     <= 1'b0;
`endif
      if (bus.i_tx_done)
        tx_busy <= 1'b0;
      if (en && cycle_cnt != '1)
        cycle_cnt <= cycle_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (bus.i_rx_done) begin
            case (bus.i_rx_data)
              8'h01: state <= LOAD_CNT;
              8'h02: begin
                cycle_cnt <= '0;
                enable_q  <= 1'b1;
                state     <= RUN;
              end
              8'h03: begin
                cycle_cnt <= '0;
                enable_q  <= 1'b1;
                state     <= STEP;
              end
              8'h04: begin
                cycle_cnt <= '0;
                state     <= DUMP_LATCH;
              end
              default: state <= IDLE;
            endcase
          end
        end
        LOAD_CNT: begin
          if (bus.i_rx_done) begin
            if (bus.i_rx_data == 8'h00) begin
              ack_q <= 8'h00;
              state <= SEND_ACK;
            end else begin
              inst_total <= bus.i_rx_data;
              inst_idx   <= '0;
              byte_idx   <= '0;
              state      <= LOAD_DATA;
            end
          end
        end
        // Bytes arrive LSB-first, so each one enters at the top of the word.
        LOAD_DATA: begin
          if (bus.i_rx_done) begin
            word_q <= {bus.i_rx_data, word_q[INSTRUCTION_BITS-1:8]};
            if (byte_idx == BI_W'(IB - 1)) begin
              byte_idx    <= '0;
              write_q     <= 1'b1;
              inst_addr_q <= PC_BITS'(inst_idx);
              inst_idx    <= inst_idx + 8'd1;
              if (inst_idx + 8'd1 == inst_total) begin
                ack_q <= inst_total;
                state <= SEND_ACK;
              end
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        SEND_ACK: begin
          if (!tx_busy) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= ack_q;
            tx_busy    <= 1'b1;
            state      <= IDLE;
          end
        end
        RUN: begin
          if (bus.i_halt) begin
            enable_q <= 1'b0;
            state    <= DUMP_LATCH;
          end
        end
        STEP: begin
          enable_q <= 1'b0;
          state    <= DUMP_LATCH;
        end
        DUMP_LATCH: begin
          dump_q    <= {bus.i_snapshot, cycle_cnt};
          dump_left <= DL_W'(HDR_BYTES);
          state     <= DUMP_TX;
        end
        DUMP_TX: begin
          if (!tx_busy) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= dump_q[7:0];
            tx_busy    <= 1'b1;
            dump_q     <= dump_q >> 8;
            dump_left  <= dump_left - 1'b1;
            if (dump_left == DL_W'(1)) begin
`ifdef DBG_MEM_DUMP_EN
              read_addr_q <= '0;
              state       <= MEM_REQ;
`else
              state       <= IDLE;
`endif
            end
          end
        end
`ifdef DBG_MEM_DUMP_EN
        // Read strobe is high during MEM_WAIT; memory answers one cycle later.
        MEM_REQ: begin
          read_q <= 1'b1;
          state  <= MEM_WAIT;
        end
        MEM_WAIT: state <= MEM_SAMPLE;
        MEM_SAMPLE: begin
          dump_q[PROC_BITS-1:0] <= bus.i_mem_data;
          dump_left             <= DL_W'(WB);
          state                 <= MEM_TX;
        end
        MEM_TX: begin
          if (!tx_busy) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= dump_q[7:0];
            tx_busy    <= 1'b1;
            dump_q     <= dump_q >> 8;
            dump_left  <= dump_left - 1'b1;
            if (dump_left == DL_W'(1)) begin
              read_addr_q <= read_addr_q + 1'b1;
              state       <= (read_addr_q == '1) ? IDLE : MEM_REQ;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_tx_start       = tx_start_q;
  assign bus.o_tx_data        = tx_data_q;
  assign bus.o_enable         = en;
  assign bus.o_write_inst_mem = write_q;
  assign bus.o_inst_mem_addr  = inst_addr_q;
  assign bus.o_inst_mem_data  = word_q;
  assign bus.o_busy           = (state != IDLE);

`ifdef DBG_MEM_DUMP_EN
  assign bus.o_debug_read_data    = read_q;
  assign bus.o_debug_read_address = read_addr_q;
`else
  logic [PROC_BITS-1:0] unused_mem;
  assign unused_mem               = bus.i_mem_data;
  assign bus.o_debug_read_data    = 1'b0;
  assign bus.o_debug_read_address = {DATA_ADDRS_BITS{1'b0}};
`endif
endmodule

// File: tb/tb_debug_controller.sv
// Directed self-checking bench for debug_controller (load, run, step, dump, mid-load reset).
// Build with DBG_MEM_DUMP_EN defined to also check the data memory dump.
module tb_debug_controller;
  localparam int SB = 128;
`ifdef DBG_MEM_DUMP_EN
  localparam int DUMP_BYTES = 4 + SB + 32 * 4;
`else
  localparam int DUMP_BYTES = 4 + SB;
`endif

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   en_cnt = 0;
  int   excl_viol = 0;
  int   overlap = 0;
  int   tx_outstanding = 0;
  int   tx_wait = 0;
  logic [7:0]  tx_q[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  debug_controller_if bus ();

  debug_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] snapByte(input int k);
    return 8'(k * 3 + 1);
  endfunction

  // Observers and UART transmitter model, all acting on the falling edge.
  always @(negedge clk) begin
    if (bus.o_enable) en_cnt++;
    if (bus.o_enable && bus.o_write_inst_mem) excl_viol++;
    if (bus.o_write_inst_mem) begin
      wr_addr.push_back(bus.o_inst_mem_addr);
      wr_data.push_back(bus.o_inst_mem_data);
    end
    bus.i_tx_done = 1'b0;
    if (bus.o_tx_start) begin
      if (tx_outstanding != 0) overlap++;
      tx_q.push_back(bus.o_tx_data);
      tx_outstanding = 1;
      tx_wait = 3;
    end else if (tx_outstanding != 0) begin
      if (tx_wait == 0) begin
        bus.i_tx_done  = 1'b1;
        tx_outstanding = 0;
      end else begin
        tx_wait--;
      end
    end
  end

  // Data memory with mem[i] = i and one cycle of read latency.
  always @(posedge clk) begin
    if (bus.o_debug_read_data)
      bus.i_mem_data <= 32'(bus.o_debug_read_address);
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clk);
    #1;
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    @(posedge clk);
    #1;
    bus.i_rx_done = 1'b0;
  endtask

  task automatic waitTx(input int n);
    int t = 0;
    while (tx_q.size() < n && t < 5000) begin
      @(posedge clk);
      t++;
    end
    checkOutput("tx_count", 64'(tx_q.size()), 64'(n));
  endtask

  task automatic waitIdle();
    int t = 0;
    while (bus.o_busy && t < 5000) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    checkOutput("idle", 64'(bus.o_busy), 64'd0);
  endtask

  task automatic checkDump(input logic [31:0] cyc);
    waitTx(DUMP_BYTES);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("cnt%0d", i), 64'(tx_q[i]), 64'(cyc[i*8 +: 8]));
    for (int k = 0; k < SB; k++)
      checkOutput($sformatf("snap%0d", k), 64'(tx_q[4+k]), 64'(snapByte(k)));
`ifdef DBG_MEM_DUMP_EN
    for (int w = 0; w < 32; w++)
      for (int b = 0; b < 4; b++)
        checkOutput($sformatf("mem%0d_%0d", w, b), 64'(tx_q[4+SB+w*4+b]),
                    (b == 0) ? 64'(w) : 64'd0);
`endif
    waitIdle();
  endtask

  task automatic checkResetOutputs(input string tag);
    @(negedge clk);
    checkOutput({tag, "_busy"},  64'(bus.o_busy), 64'd0);
    checkOutput({tag, "_en"},    64'(bus.o_enable), 64'd0);
    checkOutput({tag, "_start"}, 64'(bus.o_tx_start), 64'd0);
    checkOutput({tag, "_txd"},   64'(bus.o_tx_data), 64'd0);
    checkOutput({tag, "_wr"},    64'(bus.o_write_inst_mem), 64'd0);
    checkOutput({tag, "_addr"},  64'(bus.o_inst_mem_addr), 64'd0);
    checkOutput({tag, "_data"},  64'(bus.o_inst_mem_data), 64'd0);
    checkOutput({tag, "_rd"},    64'(bus.o_debug_read_data), 64'd0);
    checkOutput({tag, "_rda"},   64'(bus.o_debug_read_address), 64'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst           = 1'b0;
    bus.i_rx_done = 1'b0;
    bus.i_rx_data = '0;
    bus.i_tx_done = 1'b0;
    bus.i_halt    = 1'b0;
    bus.i_mem_data = '0;
    for (int k = 0; k < SB; k++)
      bus.i_snapshot[k*8 +: 8] = snapByte(k);
    repeat (3) @(posedge clk);
    checkResetOutputs("rst0");
    @(posedge clk);
    #1 rst = 1'b1;

    // Unknown command byte is ignored.
    applyStimulus(8'h55);
    @(negedge clk);
    checkOutput("ignore_busy", 64'(bus.o_busy), 64'd0);

    // LOAD two instructions.
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h78); applyStimulus(8'h56); applyStimulus(8'h34); applyStimulus(8'h12);
    applyStimulus(8'hEF); applyStimulus(8'hBE); applyStimulus(8'hAD); applyStimulus(8'hDE);
    waitTx(1);
    checkOutput("load_ack",   64'(tx_q[0]), 64'h02);
    checkOutput("load_nwr",   64'(wr_addr.size()), 64'd2);
    checkOutput("load_addr0", 64'(wr_addr[0]), 64'd0);
    checkOutput("load_data0", 64'(wr_data[0]), 64'h12345678);
    checkOutput("load_addr1", 64'(wr_addr[1]), 64'd1);
    checkOutput("load_data1", 64'(wr_data[1]), 64'hDEADBEEF);
    waitIdle();

    // LOAD with zero instructions.
    tx_q.delete();
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    waitTx(1);
    checkOutput("load0_ack", 64'(tx_q[0]), 64'h00);
    waitIdle();
    checkOutput("load0_nwr", 64'(wr_addr.size()), 64'd2);

    // RUN, halt after five enabled cycles.
    tx_q.delete();
    en_cnt = 0;
    applyStimulus(8'h02);
    for (int t = 0; t < 50; t++) begin
      @(posedge clk);
      if (en_cnt >= 5) break;
    end
    #1 bus.i_halt = 1'b1;
    @(negedge clk);
    checkOutput("run_halt_gate", 64'(bus.o_enable), 64'd0);
    @(posedge clk);
    #1 bus.i_halt = 1'b0;
    checkOutput("run_en_cycles", 64'(en_cnt), 64'd5);
    checkDump(32'd5);

    // STEP.
    tx_q.delete();
    en_cnt = 0;
    applyStimulus(8'h03);
    checkDump(32'd1);
    checkOutput("step_en_cycles", 64'(en_cnt), 64'd1);

    // Reset in the middle of an instruction load, then a plain DUMP.
    tx_q.delete();
    applyStimulus(8'h01);
    applyStimulus(8'h01);
    applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33);
    #1 rst = 1'b0;
    @(posedge clk);
    checkResetOutputs("midrst");
    checkOutput("midrst_nwr", 64'(wr_addr.size()), 64'd2);
    @(posedge clk);
    #1 rst = 1'b1;
    applyStimulus(8'h04);
    checkDump(32'd0);

    repeat (10) @(posedge clk);
    checkOutput("tx_overlap", 64'(overlap), 64'd0);
    checkOutput("en_wr_excl", 64'(excl_viol), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
